// File: rtl/ysyx_22050550_wb_arbiter_pkg.sv
// Shared widths, requester indices and payload type for the writeback arbiter.
// Requester order on the packed request buses is ALU=0, LSU=1, MDU=2.
package ysyx_22050550_wb_arbiter_pkg;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 64;
  localparam int unsigned PCW  = 64;
  localparam int unsigned CNTW = 64;
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  // One retiring instruction as seen by the regfile write / scoreboard clear port
  typedef struct packed {
    logic           wen;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [PCW-1:0] pc;
  } wb_req_t;

  // Advance a requester index modulo NREQ
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    if (32'(idx) >= NREQ - 1) rr_next = '0;
    else                      rr_next = idx + IW'(1);
  endfunction

endpackage

// File: rtl/ysyx_22050550_wb_arbiter_if.sv
// Request side and WBU/commit side of the writeback arbiter.
// master = execution units plus WBU consumers, slave = the arbiter.
interface ysyx_22050550_wb_arbiter_if;
  import ysyx_22050550_wb_arbiter_pkg::*;

  logic [NREQ-1:0]     io_req_valid;
  logic [NREQ-1:0]     io_req_ready;
  logic [NREQ-1:0]     io_req_wen;
  logic [NREQ*AW-1:0]  io_req_waddr;
  logic [NREQ*DW-1:0]  io_req_wdata;
  logic [NREQ*PCW-1:0] io_req_pc;

  logic                io_WBU_wen;
  logic [AW-1:0]       io_WBU_waddr;
  logic [DW-1:0]       io_WBU_wdata;
  logic                io_commit_valid;
  logic [PCW-1:0]      io_commit_pc;
  logic [CNTW-1:0]     io_instret;

  modport master (
    output io_req_valid, io_req_wen, io_req_waddr, io_req_wdata, io_req_pc,
    input  io_req_ready,
    input  io_WBU_wen, io_WBU_waddr, io_WBU_wdata,
    input  io_commit_valid, io_commit_pc, io_instret
  );

  modport slave (
    input  io_req_valid, io_req_wen, io_req_waddr, io_req_wdata, io_req_pc,
    output io_req_ready,
    output io_WBU_wen, io_WBU_waddr, io_WBU_wdata,
    output io_commit_valid, io_commit_pc, io_instret
  );

endinterface

// File: rtl/ysyx_22050550_rr_arb.sv
// Round-robin pick among NREQ requesters; pointer moves past the winner on fire.
// Grant is forced to zero while reset is low so nothing can fire on a reset edge.
module ysyx_22050550_rr_arb
  import ysyx_22050550_wb_arbiter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant_c,
  output logic [IW-1:0]   grant_idx_c,
  output logic            fire_c
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] scan_idx;
  logic          found;

  // Scan rr_ptr, rr_ptr+1, ... and take the first valid requester
  always_comb begin
    grant_c     = '0;
    grant_idx_c = rr_ptr;
    found       = 1'b0;
    scan_idx    = rr_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && valid[scan_idx]) begin
        found       = 1'b1;
        grant_idx_c = scan_idx;
      end
      scan_idx = rr_next(scan_idx);
    end
    fire_c = found && reset;
    if (fire_c) grant_c[grant_idx_c] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset)      rr_ptr <= '0;
    else if (fire_c) rr_ptr <= rr_next(grant_idx_c);
  end

endmodule

// File: rtl/ysyx_22050550_wb_arbiter.sv
// Writeback arbiter: grants one requester per cycle onto the regfile write /
// scoreboard clear port and produces the commit strobe, commit PC and minstret count.
module ysyx_22050550_wb_arbiter
  import ysyx_22050550_wb_arbiter_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  ysyx_22050550_wb_arbiter_if.slave     bus
);

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            fire;

  wb_req_t         sel_c;
  wb_req_t         wb_q;
  logic            commit_q;
  logic [CNTW-1:0] instret_q;

  ysyx_22050550_rr_arb u_rr_arb (
    .clock       (clock),
    .reset       (reset),
    .valid       (bus.io_req_valid),
    .grant_c     (grant),
    .grant_idx_c (grant_idx),
    .fire_c      (fire)
  );

  assign bus.io_req_ready = grant;

  // Payload of the granted requester
  always_comb begin
    sel_c       = '0;
    sel_c.wen   = bus.io_req_wen[grant_idx];
    sel_c.waddr = bus.io_req_waddr[32'(grant_idx)*AW +: AW];
    sel_c.wdata = bus.io_req_wdata[32'(grant_idx)*DW +: DW];
    sel_c.pc    = bus.io_req_pc[32'(grant_idx)*PCW +: PCW];
  end

  // x0 writes still retire but never raise the write/clear enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_q      <= '0;
      commit_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      commit_q <= fire;
      if (fire) begin
        wb_q.wen   <= sel_c.wen && (sel_c.waddr != '0);
        wb_q.waddr <= sel_c.waddr;
        wb_q.wdata <= sel_c.wdata;
        wb_q.pc    <= sel_c.pc;
        instret_q  <= instret_q + CNTW'(1);
      end else begin
        wb_q.wen   <= 1'b0;
      end
    end
  end

  assign bus.io_WBU_wen      = wb_q.wen;
  assign bus.io_WBU_waddr    = wb_q.waddr;
  assign bus.io_WBU_wdata    = wb_q.wdata;
  assign bus.io_commit_valid = commit_q;
  assign bus.io_commit_pc    = wb_q.pc;
  assign bus.io_instret      = instret_q;

endmodule

// File: tb/tb_ysyx_22050550_wb_arbiter.sv
// Scoreboard bench for the writeback arbiter: stimulus pushes expected commits,
// a monitor pops and compares whenever io_commit_valid is seen.
module tb_ysyx_22050550_wb_arbiter;
  import ysyx_22050550_wb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_22050550_wb_arbiter_if bus ();

  ysyx_22050550_wb_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [63:0] instret;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] instret_m = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One cycle of stimulus; exp_rdy is the hand-computed grant
  task automatic drive(input bit rst, input logic [2:0] v, input logic [2:0] w,
                       input logic [14:0] wa, input logic [191:0] wd,
                       input logic [191:0] pc, input logic [2:0] exp_rdy,
                       input string name);
    @(negedge clock);
    reset            = rst;
    bus.io_req_valid = v;
    bus.io_req_wen   = w;
    bus.io_req_waddr = wa;
    bus.io_req_wdata = wd;
    bus.io_req_pc    = pc;
    #1;
    check({name, " ready"}, 64'(bus.io_req_ready), 64'(exp_rdy));
    if (!rst) instret_m = '0;
    if (exp_rdy != 3'b000) begin
      exp_t e;
      int   g;
      g          = oh_idx(exp_rdy);
      instret_m  = instret_m + 64'd1;
      e.waddr    = wa[g*5 +: 5];
      e.wen      = w[g] && (e.waddr != 5'd0);
      e.wdata    = wd[g*64 +: 64];
      e.pc       = pc[g*64 +: 64];
      e.instret  = instret_m;
      q.push_back(e);
      last = e;
    end
  endtask

  // Monitor: every presented commit must match the oldest expectation
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (bus.io_commit_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_commit: got pc %h expected no commit", bus.io_commit_pc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("commit wen",     64'(bus.io_WBU_wen),   64'(e.wen));
          check("commit waddr",   64'(bus.io_WBU_waddr), 64'(e.waddr));
          check("commit wdata",   bus.io_WBU_wdata,      e.wdata);
          check("commit pc",      bus.io_commit_pc,      e.pc);
          check("commit instret", bus.io_instret,        e.instret);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            s[3];
    logic [14:0]   wa;
    logic [191:0]  wd;
    logic [191:0]  pc;
    logic [2:0]    er;

    bus.io_req_valid = '0;
    bus.io_req_wen   = '0;
    bus.io_req_waddr = '0;
    bus.io_req_wdata = '0;
    bus.io_req_pc    = '0;

    // Reset held for three cycles with everyone requesting
    repeat (3) drive(1'b0, 3'b111, 3'b111, '1, '1, '1, 3'b000, "reset");
    @(posedge clock); #2;
    check("reset commit_valid", 64'(bus.io_commit_valid), 64'd0);
    check("reset wen",          64'(bus.io_WBU_wen),      64'd0);
    check("reset instret",      bus.io_instret,           64'd0);
    check("reset waddr",        64'(bus.io_WBU_waddr),    64'd0);
    check("reset wdata",        bus.io_WBU_wdata,         64'd0);
    check("reset pc",           bus.io_commit_pc,         64'd0);

    // Contention: grants rotate 0,1,2,0,1,2 starting from index 0
    s = '{0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 3; r++) begin
        wa[r*5 +: 5]   = 5'(8*r + s[r] + 1);
        wd[r*64 +: 64] = 64'h0000_A000 + 64'(16*r + s[r]);
        pc[r*64 +: 64] = 64'h8000_1000 + 64'(256*r + 4*s[r]);
      end
      er = 3'b001 << (i % 3);
      drive(1'b1, 3'b111, 3'b111, wa, wd, pc, er, "contention");
      if (i > 0) check("contention commit_valid", 64'(bus.io_commit_valid), 64'd1);
      s[i % 3]++;
    end

    // Idle cycle: strobes drop, payload holds
    drive(1'b1, 3'b000, 3'b000, '0, '0, '0, 3'b000, "idle");
    @(posedge clock); #2;
    check("idle commit_valid", 64'(bus.io_commit_valid), 64'd0);
    check("idle wen",          64'(bus.io_WBU_wen),      64'd0);
    check("idle waddr hold",   64'(bus.io_WBU_waddr),    64'(last.waddr));
    check("idle wdata hold",   bus.io_WBU_wdata,         last.wdata);
    check("idle pc hold",      bus.io_commit_pc,         last.pc);
    check("idle instret",      bus.io_instret,           64'd6);

    // Single LSU load (rr_ptr back at 0)
    drive(1'b1, 3'b010, 3'b010, {5'd0, 5'd5, 5'd0},
          {64'd0, 64'h1234, 64'd0}, {64'd0, 64'h8000_0004, 64'd0}, 3'b010, "lsu_load");

    // ALU write to x0 (rr_ptr=2 wraps to 0), then MDU store-like wen=0 to x7
    drive(1'b1, 3'b001, 3'b001, {5'd0, 5'd0, 5'd0},
          {64'd0, 64'd0, 64'hDEAD}, {64'd0, 64'd0, 64'h8000_0100}, 3'b001, "alu_x0");
    drive(1'b1, 3'b100, 3'b000, {5'd7, 5'd0, 5'd0},
          {64'hBEEF, 64'd0, 64'd0}, {64'h8000_0200, 64'd0, 64'd0}, 3'b100, "mdu_nowen");
    check("x0 commit_valid", 64'(bus.io_commit_valid), 64'd1);

    // Fairness: ALU always valid, LSU joins on the fourth cycle
    wa = {5'd0, 5'd9, 5'd3};
    wd = {64'd0, 64'h5555, 64'h3333};
    pc = {64'd0, 64'h8000_0400, 64'h8000_0300};
    drive(1'b1, 3'b001, 3'b011, wa, wd, pc, 3'b001, "fair0");
    drive(1'b1, 3'b001, 3'b011, wa, wd, pc, 3'b001, "fair1");
    drive(1'b1, 3'b001, 3'b011, wa, wd, pc, 3'b001, "fair2");
    drive(1'b1, 3'b011, 3'b011, wa, wd, pc, 3'b010, "fair3");
    drive(1'b1, 3'b001, 3'b011, wa, wd, pc, 3'b001, "fair4");

    // Mid-operation reset: LSU fires (rr_ptr -> 2), then reset clears everything
    drive(1'b1, 3'b010, 3'b010, {5'd0, 5'd11, 5'd0},
          {64'd0, 64'h7777, 64'd0}, {64'd0, 64'h8000_0500, 64'd0}, 3'b010, "pre_reset");
    drive(1'b0, 3'b111, 3'b111, '1, '1, '1, 3'b000, "midreset");
    @(posedge clock); #2;
    check("midreset commit_valid", 64'(bus.io_commit_valid), 64'd0);
    check("midreset wen",          64'(bus.io_WBU_wen),      64'd0);
    check("midreset instret",      bus.io_instret,           64'd0);
    drive(1'b0, 3'b111, 3'b111, '1, '1, '1, 3'b000, "midreset2");
    drive(1'b1, 3'b111, 3'b111, {5'd2, 5'd2, 5'd1},
          {64'h3, 64'h2, 64'h1}, {64'h8000_0608, 64'h8000_0604, 64'h8000_0600},
          3'b001, "post_reset");
    drive(1'b1, 3'b000, 3'b000, '0, '0, '0, 3'b000, "final_idle");
    @(posedge clock); #2;
    check("final commit_valid", 64'(bus.io_commit_valid), 64'd0);
    check("final instret",      bus.io_instret,           64'd1);

    repeat (2) @(posedge clock);
    #3;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_wb_arbiter.md
Name: ysyx_22050550_wb_arbiter

Overview:
Writeback arbiter for the single register-file write port, which is also the scoreboard busy-clear port.
Three execution requesters compete for that port: ALU (EXU result), LSU (load data) and MDU (mul/div).
The block grants one requester per cycle round-robin and registers the winner onto the WBU write/clear interface. It also produces the commit strobe, commit PC and the retired-instruction counter for the minstret CSR.

Parameters:
NREQ, 3, number of requesters (index 0=ALU, 1=LSU, 2=MDU)
AW, 5, register address width
DW, 64, write data width
PCW, 64, PC width

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
io_req_valid  in  NREQ  per-requester writeback request
io_req_ready  out  NREQ  per-requester grant (one-hot or zero)
io_req_wen  in  NREQ  requester intends a register write (0 for store/branch)
io_req_waddr  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
io_req_wdata  in  NREQ*DW  write data, packed as above
io_req_pc  in  NREQ*PCW  PC of the retiring instruction, packed as above
io_WBU_wen  out  1  register write enable; also the scoreboard clear enable
io_WBU_waddr  out  AW  register write address; also the scoreboard clear address
io_WBU_wdata  out  DW  register write data
io_commit_valid  out  1  one instruction retires this cycle
io_commit_pc  out  PCW  PC of the retiring instruction
io_instret  out  64  retired-instruction count

Behaviour:
- Reset: reset==0 at a rising edge clears the following to 0: rr_ptr, io_commit_valid, io_WBU_wen, io_WBU_waddr, io_WBU_wdata, io_commit_pc, io_instret.
- While reset==0, io_req_ready is forced to 0, so no handshake can fire.
- Grant selection (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NREQ.
  - The first index with io_req_valid=1 is granted and its io_req_ready is set to 1. All other ready bits are 0.
  - If no request is valid, ready is all 0.
- Handshake:
  - fire_i = valid_i & ready_i.
  - A requester holds valid and its payload stable until it fires, and may drop valid only after firing.
  - ready does not depend on the downstream side: the regfile never stalls, so throughput is 1 commit per cycle.
- Output register (latency exactly 1 cycle from fire):
  - On a fire edge: io_commit_valid<=1; io_commit_pc<=pc_g; io_WBU_waddr<=waddr_g; io_WBU_wdata<=wdata_g; io_WBU_wen<=wen_g & (waddr_g!=0).
  - On an edge with no fire: io_commit_valid<=0 and io_WBU_wen<=0. waddr, wdata and pc hold their previous values.
- x0 rule: a write to x0 never asserts io_WBU_wen, but the instruction still commits.
- Pointer: on fire, rr_ptr<=(g+1) mod NREQ. With no fire, rr_ptr holds.
  - A requester that stays continuously valid is granted within NREQ cycles.
  - Back-to-back grants to the same requester are allowed when it is the only one valid.
- instret: increments by 1 on every fire edge, in the same edge that loads io_commit_valid=1. It wraps from 2^64-1 to 0.
- Ordering:
  - Requests from one requester are committed in the order they are presented.
  - No ordering is enforced across requesters. WAW safety comes from the IDU stalling on a busy destination at the scoreboard.
- Scoreboard interaction:
  - io_WBU_wen/io_WBU_waddr drive the scoreboard clear port directly.
  - If IDU sets the same register in the same cycle, the IDU set wins (scoreboard rule); the arbiter does nothing special.
- Reset mid-operation: a fire is impossible on a reset edge because ready=0. A commit already registered is cleared. Requesters re-present after reset.

Decomposition:
- Shared define file:
  - requester index constants (ALU=0, LSU=1, MDU=2)
  - NREQ/AW/DW/PCW defaults
  - a packed-field slice macro for the request buses
- Sub-module ysyx_22050550_rr_arb:
  - contains the rr_ptr register and the combinational rotating priority pick
  - outputs a one-hot grant and the grant index
- The top level holds the output/commit registers and instret, built from the team's parameterised register cell.

Test Plan:
- Reset: reset=0 for 3 cycles with all valid=1 -> io_req_ready=000, io_commit_valid=0, io_WBU_wen=0, io_instret=0. After release, the first grant goes to index 0.
- Single LSU load: valid[1]=1, wen=1, waddr=5, wdata=0x1234, pc=0x80000004 -> ready=010 in the same cycle. Next cycle: io_WBU_wen=1, waddr=5, wdata=0x1234, commit_pc=0x80000004, instret=1. The scoreboard bit 5 clears one edge later.
- Contention: all three valid continuously from rr_ptr=0 -> grants 0,1,2,0,1,2 on consecutive cycles, ready always one-hot, instret +1 each cycle, commit_valid held at 1.
- x0 and store: ALU wen=1, waddr=0, then MDU wen=0, waddr=7 -> io_commit_valid=1 both cycles, io_WBU_wen=0 both cycles, scoreboard bit 7 unchanged.
- Fairness: ALU valid continuously, LSU raises valid at cycle 3 -> LSU is granted no later than cycle 4, and ALU is never granted twice in a row while LSU waits.
- Mid-op reset: fire at cycle N, reset=0 at edge N+1 -> io_commit_valid=0, io_WBU_wen=0, instret=0 after that edge, and ready stays 000 until reset=1.
